// File: rtl/cam_seq_pkg.sv
// cam_seq_pkg: shared definitions for the camera power sequencer.
//   - state_e        : sequencer state encoding
//   - DEF_*          : default timing constants (25 MHz clock)
//   - out_t          : registered output bundle (excluding retry count)
//   - decode_outputs : pin levels for a given state
//   - eff_cycles     : timed-state length, with 0 promoted to 1
//   - is_timed       : states whose length is governed by the cycle timer
package cam_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PWDN      = 3'd1,
    RESET     = 3'd2,
    SETTLE    = 3'd3,
    START     = 3'd4,
    WAIT_INIT = 3'd5,
    RUN       = 3'd6,
    FAULT     = 3'd7
  } state_e;

  localparam int unsigned DEF_CNT_W       = 20;
  localparam int unsigned DEF_PWDN_CYC    = 25000;
  localparam int unsigned DEF_RST_CYC     = 50000;
  localparam int unsigned DEF_SETTLE_CYC  = 525000;
  localparam int unsigned DEF_PULSE_CYC   = 5;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000000;
  localparam int unsigned DEF_MAX_RETRY   = 3;

  typedef struct packed {
    logic cam_pwdn;
    logic cam_resetb_oe;
    logic init_start;
    logic started;
    logic fault;
  } out_t;

  // Pin levels per state; the camera stays powered down and held in reset
  // whenever it is idle or has faulted.
  function automatic out_t decode_outputs(input state_e st);
    out_t o;
    o = '{cam_pwdn: 1'b1, cam_resetb_oe: 1'b1, init_start: 1'b0,
          started: 1'b0, fault: 1'b0};
    case (st)
      IDLE, PWDN: begin
        o.cam_pwdn      = 1'b1;
        o.cam_resetb_oe = 1'b1;
      end
      RESET: begin
        o.cam_pwdn      = 1'b0;
        o.cam_resetb_oe = 1'b1;
      end
      SETTLE, WAIT_INIT: begin
        o.cam_pwdn      = 1'b0;
        o.cam_resetb_oe = 1'b0;
      end
      START: begin
        o.cam_pwdn      = 1'b0;
        o.cam_resetb_oe = 1'b0;
        o.init_start    = 1'b1;
      end
      RUN: begin
        o.cam_pwdn      = 1'b0;
        o.cam_resetb_oe = 1'b0;
        o.started       = 1'b1;
      end
      FAULT: begin
        o.cam_pwdn      = 1'b1;
        o.cam_resetb_oe = 1'b1;
        o.fault         = 1'b1;
      end
      default: begin
        o.cam_pwdn      = 1'b1;
        o.cam_resetb_oe = 1'b1;
      end
    endcase
    return o;
  endfunction

  // A zero-length state would otherwise never see the timer reach its count.
  function automatic int unsigned eff_cycles(input int unsigned c);
    return (c == 32'd0) ? 32'd1 : c;
  endfunction

  function automatic logic is_timed(input state_e st);
    logic t;
    case (st)
      PWDN, RESET, SETTLE, START, WAIT_INIT: t = 1'b1;
      default:                               t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable, clearable up-counter with a done flag.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   clr_i      : synchronous clear (count -> 0), highest priority after reset
//   load_i     : load load_val_i into the counter
//   load_val_i : value loaded on load_i
//   target_i   : count at which done_o asserts
//   count_o    : current count
//   done_o     : count has reached target_i
module seq_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] target_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, load, or increment; holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '1) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q >= target_i);

endmodule

// File: rtl/cam_power_seq.sv
// cam_power_seq: camera power-up / reset / register-load sequencer.
// Sequence: IDLE -> PWDN -> RESET -> SETTLE -> START -> WAIT_INIT -> RUN,
// retrying from RESET on load error/timeout, FAULT once retries run out.
//   meg25         : 25 MHz clock
//   rst           : synchronous active-high reset
//   enable        : 1 requests power-up, 0 forces shutdown to IDLE
//   init_done     : register-load engine finished OK
//   init_err      : register-load engine error
//   cam_pwdn      : camera power-down pin (1 = powered down)
//   cam_resetb_oe : 1 drives RESETB low, 0 releases it to the pull-up
//   init_start    : start pulse to the register-load engine
//   started       : camera initialised and running
//   fault         : retries exhausted
//   retry_cnt     : retries consumed so far
module cam_power_seq
  import cam_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PWDN_CYC    = DEF_PWDN_CYC,
  parameter int unsigned RST_CYC     = DEF_RST_CYC,
  parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
  input  logic       meg25,
  input  logic       rst,
  input  logic       enable,
  input  logic       init_done,
  input  logic       init_err,
  output logic       cam_pwdn,
  output logic       cam_resetb_oe,
  output logic       init_start,
  output logic       started,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if ((64'(PWDN_CYC) > CNT_MAX) || (64'(RST_CYC) > CNT_MAX) ||
      (64'(SETTLE_CYC) > CNT_MAX) || (64'(PULSE_CYC) > CNT_MAX) ||
      (64'(TIMEOUT_CYC) > CNT_MAX)) begin : g_bad_timing
    $error("cam_power_seq: timing parameter exceeds 2^CNT_W-1");
  end
  if (MAX_RETRY > 32'd3) begin : g_bad_retry
    $error("cam_power_seq: MAX_RETRY does not fit retry_cnt");
  end

  localparam logic [CNT_W-1:0] PWDN_T    = CNT_W'(eff_cycles(PWDN_CYC));
  localparam logic [CNT_W-1:0] RST_T     = CNT_W'(eff_cycles(RST_CYC));
  localparam logic [CNT_W-1:0] SETTLE_T  = CNT_W'(eff_cycles(SETTLE_CYC));
  localparam logic [CNT_W-1:0] PULSE_T   = CNT_W'(eff_cycles(PULSE_CYC));
  localparam logic [CNT_W-1:0] TIMEOUT_T = CNT_W'(eff_cycles(TIMEOUT_CYC));
  localparam logic [CNT_W-1:0] TMR_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       MAX_R     = 2'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [1:0]       retry_q, retry_d;
  out_t             out_q, out_d;
  logic [CNT_W-1:0] tmr_target_s;
  logic [CNT_W-1:0] tmr_count_s;
  logic             tmr_done_s;
  logic             tmr_load_s;
  logic             tmr_clr_s;
  logic             attempt_fail_s;

  // The timer is loaded with 1 on entry so that the entry cycle counts as the
  // first cycle; the state exits on the cycle the count equals its length.
  seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (meg25),
    .rst_i     (rst),
    .clr_i     (tmr_clr_s),
    .load_i    (tmr_load_s),
    .load_val_i(TMR_ONE),
    .target_i  (tmr_target_s),
    .count_o   (tmr_count_s),
    .done_o    (tmr_done_s)
  );

  // Length of the current timed state.
  always_comb begin
    tmr_target_s = TMR_ONE;
    case (state_q)
      PWDN:      tmr_target_s = PWDN_T;
      RESET:     tmr_target_s = RST_T;
      SETTLE:    tmr_target_s = SETTLE_T;
      START:     tmr_target_s = PULSE_T;
      WAIT_INIT: tmr_target_s = TIMEOUT_T;
      default:   tmr_target_s = TMR_ONE;
    endcase
  end

  // Next-state, retry count and timer control.
  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    // init_err wins over init_done; a timeout only counts if init_done is absent.
    attempt_fail_s = init_err | (~init_done & tmr_done_s);
    if ((state_q != IDLE) && !enable) begin
      state_d = IDLE;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = PWDN;
          else        state_d = IDLE;
        end
        PWDN: begin
          if (tmr_done_s) state_d = RESET;
          else            state_d = PWDN;
        end
        RESET: begin
          if (tmr_done_s) state_d = SETTLE;
          else            state_d = RESET;
        end
        SETTLE: begin
          if (tmr_done_s) state_d = START;
          else            state_d = SETTLE;
        end
        START: begin
          if (tmr_done_s) state_d = WAIT_INIT;
          else            state_d = START;
        end
        WAIT_INIT: begin
          if (attempt_fail_s) begin
            if (retry_q < MAX_R) begin
              state_d = RESET;
              retry_d = retry_q + 2'd1;
            end else begin
              state_d = FAULT;
            end
          end else if (init_done) begin
            state_d = RUN;
          end else begin
            state_d = WAIT_INIT;
          end
        end
        RUN:     state_d = RUN;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    tmr_clr_s  = ~is_timed(state_d);
    tmr_load_s = is_timed(state_d) & (state_d != state_q);
    out_d      = decode_outputs(state_d);
  end

  // State, retry count and output registers.
  always_ff @(posedge meg25) begin
    if (rst) begin
      state_q <= IDLE;
      retry_q <= 2'd0;
      out_q   <= decode_outputs(IDLE);
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign cam_pwdn      = out_q.cam_pwdn;
  assign cam_resetb_oe = out_q.cam_resetb_oe;
  assign init_start    = out_q.init_start;
  assign started       = out_q.started;
  assign fault         = out_q.fault;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_cam_power_seq.sv
// Scoreboard bench: each scenario pushes the output changes it expects (value
// and the clock count at which they appear); a monitor pops one entry every
// time the output vector changes and compares value and timing.
// Output vector: {cam_pwdn, cam_resetb_oe, init_start, started, fault, retry_cnt[1:0]}.
module tb_cam_power_seq;

  logic       meg25 = 1'b0;
  logic       rst, enable, init_done, init_err;
  logic       cam_pwdn, cam_resetb_oe, init_start, started, fault;
  logic [1:0] retry_cnt;

  typedef struct {
    logic [6:0] val;
    int         cyc;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  bit   done_flag = 1'b0;
  int   t0;

  cam_power_seq #(
    .CNT_W(20), .PWDN_CYC(4), .RST_CYC(8), .SETTLE_CYC(16),
    .PULSE_CYC(2), .TIMEOUT_CYC(32), .MAX_RETRY(2)
  ) dut (
    .meg25(meg25), .rst(rst), .enable(enable), .init_done(init_done),
    .init_err(init_err), .cam_pwdn(cam_pwdn), .cam_resetb_oe(cam_resetb_oe),
    .init_start(init_start), .started(started), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #5 meg25 = ~meg25;

  always @(posedge meg25) cyc <= cyc + 1;

  // Monitor: compare every output change against the scoreboard head.
  logic [6:0] prev = 7'bx;
  logic [6:0] cur;
  exp_t       e;
  always @(negedge meg25) begin
    cur = {cam_pwdn, cam_resetb_oe, init_start, started, fault, retry_cnt};
    if (cur !== prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change: got %b at cycle %0d, none expected", cur, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((e.val !== cur) || (e.cyc != cyc)) begin
          n_err++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                   e.name, cur, cyc, e.val, e.cyc);
        end
      end
      prev = cur;
    end
    if (done_flag) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL leftover_expected: %0d entries never seen, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
    end
  end

  task automatic push(input string name, input logic [6:0] val, input int c);
    exp_t x;
    x.val = val; x.cyc = c; x.name = name;
    exp_q.push_back(x);
  endtask

  // Wait (at negedges) until the posedge count reaches c; inputs driven now
  // are sampled at posedge c+1.
  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge meg25);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge meg25);
    @(negedge meg25);
  endtask

  task automatic start_seq();
    @(negedge meg25);
    enable = 1'b1;
    t0 = cyc;
  endtask

  // Common prefix: PWDN 4, RESET 8, SETTLE 16, START 2, then WAIT_INIT.
  task automatic push_first_attempt(input string tag);
    push({tag, "_reset"},  7'b0100000, t0 + 5);
    push({tag, "_settle"}, 7'b0000000, t0 + 13);
    push({tag, "_start"},  7'b0010000, t0 + 29);
    push({tag, "_wait"},   7'b0000000, t0 + 31);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; init_done = 1'b0; init_err = 1'b0;
    push("reset_state", 7'b1100000, 1);
    repeat (3) @(negedge meg25);
    rst = 1'b0;

    // Nominal power-up.
    start_seq();
    push_first_attempt("nom");
    push("nom_run",     7'b0001000, t0 + 41);
    push("nom_disable", 7'b1100000, t0 + 46);
    at_cyc(t0 + 40); init_done = 1'b1;
    at_cyc(t0 + 41); init_done = 1'b0;
    at_cyc(t0 + 45); enable = 1'b0;
    wait_empty();

    // Error on first attempt, success on second; stray init_err in SETTLE ignored.
    start_seq();
    push_first_attempt("err");
    push("err_retry_reset", 7'b0100001, t0 + 34);
    push("err_settle2",     7'b0000001, t0 + 42);
    push("err_start2",      7'b0010001, t0 + 58);
    push("err_wait2",       7'b0000001, t0 + 60);
    push("err_run",         7'b0001001, t0 + 65);
    push("err_disable",     7'b1100000, t0 + 71);
    at_cyc(t0 + 33); init_err = 1'b1;
    at_cyc(t0 + 34); init_err = 1'b0;
    at_cyc(t0 + 45); init_err = 1'b1;
    at_cyc(t0 + 46); init_err = 1'b0;
    at_cyc(t0 + 64); init_done = 1'b1;
    at_cyc(t0 + 65); init_done = 1'b0;
    at_cyc(t0 + 70); enable = 1'b0;
    wait_empty();

    // Timeout on every attempt -> FAULT; init_done outside WAIT_INIT ignored.
    start_seq();
    push_first_attempt("tmo");
    push("tmo_reset2",  7'b0100001, t0 + 63);
    push("tmo_settle2", 7'b0000001, t0 + 71);
    push("tmo_start2",  7'b0010001, t0 + 87);
    push("tmo_wait2",   7'b0000001, t0 + 89);
    push("tmo_reset3",  7'b0100010, t0 + 121);
    push("tmo_settle3", 7'b0000010, t0 + 129);
    push("tmo_start3",  7'b0010010, t0 + 145);
    push("tmo_wait3",   7'b0000010, t0 + 147);
    push("tmo_fault",   7'b1100110, t0 + 179);
    push("tmo_disable", 7'b1100000, t0 + 186);
    at_cyc(t0 + 75);  init_done = 1'b1;
    at_cyc(t0 + 76);  init_done = 1'b0;
    at_cyc(t0 + 181); init_done = 1'b1;
    at_cyc(t0 + 182); init_done = 1'b0;
    at_cyc(t0 + 185); enable = 1'b0;
    wait_empty();

    // init_done and init_err together count as an error.
    start_seq();
    push_first_attempt("sim");
    push("sim_retry_reset", 7'b0100001, t0 + 36);
    push("sim_disable",     7'b1100000, t0 + 39);
    at_cyc(t0 + 35); init_done = 1'b1; init_err = 1'b1;
    at_cyc(t0 + 36); init_done = 1'b0; init_err = 1'b0;
    at_cyc(t0 + 38); enable = 1'b0;
    wait_empty();

    // Abort during SETTLE.
    start_seq();
    push("abt_reset",  7'b0100000, t0 + 5);
    push("abt_settle", 7'b0000000, t0 + 13);
    push("abt_idle",   7'b1100000, t0 + 21);
    at_cyc(t0 + 20); enable = 1'b0;
    wait_empty();

    // Re-enable restarts from PWDN; rst pulse in RUN overrides enable.
    start_seq();
    push_first_attempt("rst");
    push("rst_run",        7'b0001000, t0 + 41);
    push("rst_pulse",      7'b1100000, t0 + 46);
    push("rst_reenter",    7'b0100000, t0 + 51);
    push("rst_disable",    7'b1100000, t0 + 54);
    at_cyc(t0 + 40); init_done = 1'b1;
    at_cyc(t0 + 41); init_done = 1'b0;
    at_cyc(t0 + 45); rst = 1'b1;
    at_cyc(t0 + 46); rst = 1'b0;
    at_cyc(t0 + 53); enable = 1'b0;
    wait_empty();

    done_flag = 1'b1;
  end

endmodule

// File: doc/cam_power_seq.md
CAM_POWER_SEQ -- requirements
Module: cam_power_seq

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- CNT_W, 20, timer width in bits
- PWDN_CYC, 25000, PWDN-high hold after enable
- RST_CYC, 50000, cycles camera reset held low (2 ms at 25 MHz)
- SETTLE_CYC, 525000, post-reset settle (21 ms)
- PULSE_CYC, 5, init_start pulse width
- TIMEOUT_CYC, 1000000, max wait for init_done
- MAX_RETRY, 3, retries before fault
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- meg25, in, 1, sole clock (25 MHz)
- rst, in, 1, synchronous active-high reset
- enable, in, 1, request camera power-up; low requests shutdown
- init_done, in, 1, register-load engine finished OK
- init_err, in, 1, register-load engine NACK/error
- cam_pwdn, out, 1, camera power-down pin, high = powered down
- cam_resetb_oe, out, 1, 1 = drive RESETB low; 0 = release to board pull-up
- init_start, out, 1, start pulse to register-load engine
- started, out, 1, camera initialised and running
- fault, out, 1, retries exhausted
- retry_cnt, out, 2, retries consumed so far

Function
REQ-003 FSM states SHALL be IDLE, PWDN, RESET, SETTLE, START, WAIT_INIT, RUN, FAULT.
REQ-004 Each timed state SHALL last exactly its parameter count in cycles. The timer SHALL load on state entry. The state SHALL exit on the cycle the timer reaches the count; a count of 0 SHALL be treated as 1.
REQ-005 IDLE -> PWDN when enable=1. PWDN -> RESET after PWDN_CYC. RESET -> SETTLE after RST_CYC. SETTLE -> START after SETTLE_CYC. START -> WAIT_INIT after PULSE_CYC.
REQ-006 WAIT_INIT -> RUN on init_done=1. If init_err=1 or TIMEOUT_CYC elapse, the FSM SHALL go to RESET when retry_cnt<MAX_RETRY, incrementing retry_cnt, else to FAULT.
REQ-007 If init_done and init_err are both high in the same cycle, init_err SHALL take priority.
REQ-008 init_done and init_err SHALL be ignored outside WAIT_INIT.
REQ-009 enable=0 in any non-IDLE state SHALL force IDLE on the next cycle and clear retry_cnt. This is the only exit from RUN and FAULT besides rst.
REQ-010 Outputs SHALL be registered. cam_pwdn=1 only in IDLE, PWDN and FAULT. cam_resetb_oe=1 in IDLE, PWDN, RESET and FAULT. init_start=1 only in START. started=1 only in RUN. fault=1 only in FAULT.
REQ-011 retry_cnt SHALL saturate at MAX_RETRY and never wrap.
REQ-012 The timer SHALL be CNT_W bits wide. A parameter exceeding 2^CNT_W-1 SHALL be an elaboration error.

Reset
REQ-013 While rst=1, the block SHALL hold: state IDLE, timer 0, retry_cnt 0, cam_pwdn=1, cam_resetb_oe=1, init_start=0, started=0, fault=0.
REQ-014 rst asserted mid-sequence SHALL take effect on the next meg25 edge and SHALL override enable.

Structure
REQ-015 Package cam_seq_pkg SHALL hold the state encoding and default timing constants.
REQ-016 The cycle timer SHALL be the sub-module seq_timer, a loadable, clearable up-counter with a done flag.

Verification
All scenarios use PWDN_CYC=4, RST_CYC=8, SETTLE_CYC=16, PULSE_CYC=2, TIMEOUT_CYC=32, MAX_RETRY=2.
REQ-017 Nominal: enable=1, init_done 10 cycles after init_start falls. Required: cam_pwdn falls after 4 cycles; cam_resetb_oe falls 8 cycles later; init_start high for exactly 2 cycles; started=1 one cycle after init_done.
REQ-018 Error retry: init_err on the first attempt, init_done on the second. Required: RESET re-entered, retry_cnt=1, started=1, fault=0.
REQ-019 Timeout exhaustion: init_done never asserts. Required: three attempts, retry_cnt=2, then fault=1, cam_pwdn=1, cam_resetb_oe=1.
REQ-020 Simultaneous: init_done=init_err=1 in WAIT_INIT. Required: treated as error, retry_cnt increments.
REQ-021 Abort: enable drops during SETTLE. Required: IDLE next cycle, cam_pwdn=1, retry_cnt=0. Re-enable restarts from PWDN.
REQ-022 rst pulse in RUN. Required: all outputs at reset values next cycle.
